bitserial_dot_acc: RTL and testbench

- Parametrised bit-serial dot-product engine.
- Each beat carries one bit-plane of N_CH partial products, MSB plane first.
  - Lane k carries weight[k] × input[k][bit].
- After NBITS accepted beats it presents the full dot product on `result`.
- Adds to the fixed 32-lane, 4-plane, fixed-latency design: valid/ready flow control, a runtime two's-complement mode, and compile-time output saturation.
- Sits between the weight/bit-plane generator and the result collector in the MAC datapath.

---
 rtl/bitserial_dot_acc.sv | 127 ++++++++++++
 tb/tb_bitserial_dot_acc.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bitserial_dot_acc.sv
// rtl/bitserial_dot_acc.sv - bit-serial dot-product accumulator with valid/ready flow control
// Optional feature macro: BSDOT_SAT_EN (clamp result to the OUT_W range instead of wrapping)

module bitserial_dot_acc #(
  parameter int N_CH  = 32,
  parameter int PW    = 4,
  parameter int NBITS = 4,
  parameter int OUT_W = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_CH*PW-1:0]   in_data,
  input  logic                 mode_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     result
);

  localparam int PS_W  = PW + $clog2(N_CH);
  localparam int ACC_W = PS_W + NBITS + 1;
  localparam int CNT_W = $clog2(NBITS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NBITS - 1);

  logic [CNT_W-1:0]        cnt;
  logic                    mode_q;
  logic signed [ACC_W-1:0] acc;

  logic [PS_W-1:0]         plane_sum;
  logic signed [ACC_W-1:0] ps_ext;
  logic signed [ACC_W-1:0] acc_next;
  logic                    mode_cur;
  logic                    beat_fire;
  logic                    last_beat;
  logic [OUT_W-1:0]        res_next;

  // Only the final beat of a vector can stall: it would overwrite a result still waiting downstream
  assign in_ready  = !(out_valid && !out_ready && (cnt == LAST));
  assign beat_fire = in_valid && in_ready;
  assign last_beat = beat_fire && (cnt == LAST);

  // Unsigned sum of all lanes for the current bit-plane
  always_comb begin
    plane_sum = '0;
    for (int k = 0; k < N_CH; k++) begin
      plane_sum = plane_sum + PS_W'(in_data[k*PW +: PW]);
    end
  end

  // Mode of the vector in flight: taken live on the first beat, from the latch afterwards
  assign mode_cur = (cnt == '0) ? mode_signed : mode_q;
  assign ps_ext   = $signed({{(ACC_W-PS_W){1'b0}}, plane_sum});

  // Shift-and-add; the MSB plane is negated for two's-complement operands
  always_comb begin
    acc_next = '0;
    if (cnt == '0) begin
      acc_next = mode_cur ? -ps_ext : ps_ext;
    end else begin
      acc_next = (acc <<< 1) + ps_ext;
    end
  end

`ifdef BSDOT_SAT_EN
  // Widen enough to hold both the accumulator and the unsigned upper limit as positive signed numbers
  localparam int EXT_W = (ACC_W > OUT_W) ? ACC_W : OUT_W + 1;
  localparam logic [EXT_W-1:0] S_MAX = (EXT_W'(1) << (OUT_W - 1)) - EXT_W'(1);
  localparam logic [EXT_W-1:0] S_MIN = ~S_MAX;
  localparam logic [EXT_W-1:0] U_MAX = (EXT_W'(1) << OUT_W) - EXT_W'(1);

  logic signed [EXT_W-1:0] acc_ext;
  logic signed [EXT_W-1:0] lim_hi;
  logic signed [EXT_W-1:0] lim_lo;

  // Clamp the final accumulator to the range of the captured mode
  always_comb begin
    acc_ext  = EXT_W'(acc_next);
    lim_hi   = mode_cur ? S_MAX : U_MAX;
    lim_lo   = mode_cur ? S_MIN : '0;
    res_next = acc_ext[OUT_W-1:0];
    if (acc_ext > lim_hi) begin
      res_next = lim_hi[OUT_W-1:0];
    end else if (acc_ext < lim_lo) begin
      res_next = lim_lo[OUT_W-1:0];
    end
  end
`else
  // Keep the low OUT_W bits of the final accumulator
  always_comb begin
    res_next = OUT_W'(acc_next);
  end
`endif

  // Beat counter, mode latch and accumulator; gaps leave everything untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      mode_q <= 1'b0;
      acc    <= '0;
    end else if (beat_fire) begin
      acc <= acc_next;
      if (cnt == '0) begin
        mode_q <= mode_signed;
      end
      if (cnt == LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Output register: a new final beat replaces a consumed result on the same edge without a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
    end else if (last_beat) begin
      out_valid <= 1'b1;
      result    <= res_next;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bitserial_dot_acc.sv
// tb/tb_bitserial_dot_acc.sv - scoreboard bench for bitserial_dot_acc (default and OUT_W=10 instances)

module tb_bitserial_dot_acc;

  localparam int N_CH   = 32;
  localparam int PW     = 4;
  localparam int NBITS  = 4;
  localparam int OUT_W  = 13;
  localparam int OUT_W2 = 10;
  localparam int DW     = N_CH * PW;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              mode_signed = 1'b0;
  logic              out_ready = 1'b1;
  logic [DW-1:0]     in_data = '0;
  logic              in_ready;
  logic              out_valid;
  logic [OUT_W-1:0]  result;

  logic              in_valid2;
  logic              in_ready2;
  logic              out_valid2;
  logic [OUT_W2-1:0] result2;
  logic              out_ready2 = 1'b1;

  int n_vec = 0;
  int n_err = 0;
  int n_out = 0;
  logic [31:0] q_main[$];
  logic [31:0] q_10[$];

  always #5 clk = ~clk;

  // The narrow instance sees exactly the beats the main instance accepts
  assign in_valid2 = in_valid && in_ready;

  bitserial_dot_acc #(.N_CH(N_CH), .PW(PW), .NBITS(NBITS), .OUT_W(OUT_W)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mode_signed(mode_signed), .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  bitserial_dot_acc #(.N_CH(N_CH), .PW(PW), .NBITS(NBITS), .OUT_W(OUT_W2)) u_dut10 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data),
    .mode_signed(mode_signed), .out_valid(out_valid2), .out_ready(out_ready2), .result(result2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [DW-1:0] fill(input int v);
    logic [DW-1:0] r;
    for (int k = 0; k < N_CH; k++) r[k*PW +: PW] = PW'(v);
    return r;
  endfunction

  function automatic int psum(input logic [DW-1:0] d);
    int s = 0;
    for (int k = 0; k < N_CH; k++) s += int'(d[k*PW +: PW]);
    return s;
  endfunction

  function automatic logic [31:0] conv(input longint v, input int w, input bit s);
    longint x = v;
`ifdef BSDOT_SAT_EN
    longint hi;
    longint lo;
    hi = s ? (64'sd1 <<< (w - 1)) - 1 : (64'sd1 <<< w) - 1;
    lo = s ? -(64'sd1 <<< (w - 1)) : 64'sd0;
    if (x > hi) x = hi;
    if (x < lo) x = lo;
`endif
    return 32'(x & ((64'sd1 <<< w) - 1));
  endfunction

  task automatic push_exp(input logic [DW-1:0] p0, input logic [DW-1:0] p1,
                          input logic [DW-1:0] p2, input logic [DW-1:0] p3,
                          input bit s, output logic [31:0] e);
    longint v;
    v = longint'(psum(p0)) * 8;
    if (s) v = -v;
    v += longint'(psum(p1)) * 4 + longint'(psum(p2)) * 2 + longint'(psum(p3));
    e = conv(v, OUT_W, s);
    q_main.push_back(e);
    q_10.push_back(conv(v, OUT_W2, s));
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic m);
    bit done = 0;
    in_valid = 1'b1;
    in_data = d;
    mode_signed = m;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      if (in_ready) done = 1;
      @(posedge clk);
      #1;
    end
    if (!done) check("beat_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic send_vec(input logic [DW-1:0] p0, input logic [DW-1:0] p1,
                          input logic [DW-1:0] p2, input logic [DW-1:0] p3, input bit s);
    logic [31:0] e;
    push_exp(p0, p1, p2, p3, s, e);
    send_beat(p0, s);
    send_beat(p1, s);
    send_beat(p2, s);
    send_beat(p3, s);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_out++;
      if (q_main.size() == 0) check("spurious_out", 32'd0, 32'd1);
      else check("result", 32'(result), q_main.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid2) begin
      if (q_10.size() == 0) check("spurious_out_w10", 32'd0, 32'd1);
      else check("result_w10", 32'(result2), q_10.pop_front());
    end
  end

  initial begin
    logic [31:0] ea;
    logic [31:0] eb;
    logic [DW-1:0] r0, r1, r2, r3;
    int n0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;

    // unsigned all-15, back-to-back, with latency check on the first vector
    push_exp(fill(15), fill(15), fill(15), fill(15), 1'b0, ea);
    send_beat(fill(15), 1'b0);
    send_beat(fill(15), 1'b0);
    send_beat(fill(15), 1'b0);
    check("ov_before_last", 32'(out_valid), 32'd0);
    send_beat(fill(15), 1'b0);
    check("ov_latency", 32'(out_valid), 32'd1);
    check("first_result", 32'(result), 32'd7200);
    send_vec(fill(15), fill(15), fill(15), fill(15), 1'b0);

    // signed, MSB plane only
    send_vec(fill(1), fill(0), fill(0), fill(0), 1'b1);

    // random planes, both modes
    for (int i = 0; i < 6; i++) begin
      r0 = {$urandom, $urandom, $urandom, $urandom};
      r1 = {$urandom, $urandom, $urandom, $urandom};
      r2 = {$urandom, $urandom, $urandom, $urandom};
      r3 = {$urandom, $urandom, $urandom, $urandom};
      send_vec(r0, r1, r2, r3, 1'(i % 2));
    end
    repeat (3) idle_cycle();

    // backpressure: A waits while B streams, final beat of B stalls
    out_ready = 1'b0;
    send_vec(fill(1), fill(2), fill(3), fill(4), 1'b0);
    check("bp_a_valid", 32'(out_valid), 32'd1);
    push_exp(fill(15), fill(0), fill(0), fill(15), 1'b1, eb);
    ea = 32'd832;
    check("bp_b_ready0", 32'(in_ready), 32'd1);
    send_beat(fill(15), 1'b1);
    check("bp_b_ready1", 32'(in_ready), 32'd1);
    send_beat(fill(0), 1'b1);
    check("bp_b_ready2", 32'(in_ready), 32'd1);
    send_beat(fill(0), 1'b1);
    in_valid = 1'b1;
    in_data = fill(15);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_stall_ready", 32'(in_ready), 32'd0);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_result", 32'(result), ea);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_no_bubble", 32'(out_valid), 32'd1);
    check("bp_b_result", 32'(result), eb);
    repeat (3) idle_cycle();

    // reset in the middle of a vector, then a clean all-1 vector
    send_beat(fill(15), 1'b0);
    send_beat(fill(15), 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    n0 = n_out;
    send_vec(fill(1), fill(1), fill(1), fill(1), 1'b0);
    repeat (3) idle_cycle();
    check("rst_one_event", 32'(n_out - n0), 32'd1);

    // gaps inside a vector: valid pattern 1,0,0,1,1,0,1
    push_exp(fill(1), fill(1), fill(1), fill(1), 1'b0, ea);
    send_beat(fill(1), 1'b0);
    idle_cycle();
    idle_cycle();
    send_beat(fill(1), 1'b0);
    send_beat(fill(1), 1'b0);
    idle_cycle();
    send_beat(fill(1), 1'b0);

    repeat (5) idle_cycle();
    check("q_main_drained", 32'(q_main.size()), 32'd0);
    check("q_w10_drained", 32'(q_10.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
